// File: rtl/nios_system_sdram_pio_in_irq.sv
// Avalon-MM input port with synchroniser, per-bit debounce, edge capture and a
// maskable level interrupt.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset (synchronous release expected)
//   address    word register select: 0 data, 1 irqmask, 2 reserved, 3 edgecapture
//   chipselect slave select, qualifies writes
//   write_n    active-low write strobe
//   writedata  write data (low WIDTH bits significant)
//   readdata   registered read data, latency 1, upper bits zero
//   in_port    raw asynchronous inputs
//   irq        level interrupt, |(edgecapture & irqmask), registered
module nios_system_sdram_pio_in_irq #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [CntW-1:0]  cnt_q [WIDTH];
    logic [CntW-1:0]  cnt_d [WIDTH];
    logic [1:0]       fill_q;
    logic             primed_q;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [WIDTH-1:0] edge_set;
    logic [31:0]      readdata_d;
    logic             wr_en;
    logic             unused_wdata;

    // Upper writedata bits are unused when WIDTH < 32.
    assign unused_wdata = ^writedata;

    assign wr_en = chipselect & ~write_n;

    // Debounce and priming.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
        end
        if (!primed_q) begin
            // fill_q[1] marks sync2 holding a real sample, not its reset value.
            if (fill_q[1]) begin
                stable_d = sync2_q;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2_q[i] == stable_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CntMax) begin
                    stable_d[i] = sync2_q[i];
                    cnt_d[i]    = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CntOne;
                end
            end
        end
    end

    // Edge detect; priming loads must never look like edges.
    always_comb begin
        edge_set = '0;
        if (primed_q) begin
            case (EDGE_TYPE)
                0:       edge_set = ~stable_q & stable_d;
                1:       edge_set = stable_q & ~stable_d;
                default: edge_set = stable_q ^ stable_d;
            endcase
        end
    end

    // Register writes; a capture on the same bit as a W1C wins.
    always_comb begin
        irqmask_d = irqmask_q;
        edgecap_d = edgecap_q;
        if (wr_en && address == 2'd1) begin
            irqmask_d = writedata[WIDTH-1:0];
        end
        if (wr_en && address == 2'd3) begin
            edgecap_d = edgecap_q & ~writedata[WIDTH-1:0];
        end
        edgecap_d = edgecap_d | edge_set;
    end

    // Read mux, registered every clock from the current address.
    always_comb begin
        readdata_d = '0;
        case (address)
            2'd0:    readdata_d[WIDTH-1:0] = stable_q;
            2'd1:    readdata_d[WIDTH-1:0] = irqmask_q;
            2'd3:    readdata_d[WIDTH-1:0] = edgecap_q;
            default: readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            stable_q  <= '0;
            fill_q    <= '0;
            primed_q  <= 1'b0;
            irqmask_q <= '0;
            edgecap_q <= '0;
            readdata  <= '0;
            irq       <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= in_port;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            fill_q    <= {fill_q[0], 1'b1};
            primed_q  <= primed_q | fill_q[1];
            irqmask_q <= irqmask_d;
            edgecap_q <= edgecap_d;
            readdata  <= readdata_d;
            irq       <= |(edgecap_q & irqmask_q);
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule

// File: tb/tb_nios_system_sdram_pio_in_irq.sv
module tb_nios_system_sdram_pio_in_irq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    // DUT 0: defaults (WIDTH 8, DEBOUNCE 4, rising edge)
    logic [1:0]  d0_addr;
    logic        d0_cs, d0_wn;
    logic [31:0] d0_wd, d0_rd;
    logic [7:0]  d0_in;
    logic        d0_irq;
    // DUT 2: any-edge capture
    logic [1:0]  d2_addr;
    logic        d2_cs, d2_wn;
    logic [31:0] d2_wd, d2_rd;
    logic [7:0]  d2_in;
    logic        d2_irq;
    // DUT 3: WIDTH 3
    logic [1:0]  d3_addr;
    logic        d3_cs, d3_wn;
    logic [31:0] d3_wd, d3_rd;
    logic [2:0]  d3_in;
    logic        d3_irq;

    nios_system_sdram_pio_in_irq dut0 (
        .clk(clk), .reset_n(reset_n), .address(d0_addr), .chipselect(d0_cs),
        .write_n(d0_wn), .writedata(d0_wd), .readdata(d0_rd), .in_port(d0_in),
        .irq(d0_irq)
    );

    nios_system_sdram_pio_in_irq #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .address(d2_addr), .chipselect(d2_cs),
        .write_n(d2_wn), .writedata(d2_wd), .readdata(d2_rd), .in_port(d2_in),
        .irq(d2_irq)
    );

    nios_system_sdram_pio_in_irq #(.WIDTH(3), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) dut3 (
        .clk(clk), .reset_n(reset_n), .address(d3_addr), .chipselect(d3_cs),
        .write_n(d3_wn), .writedata(d3_wd), .readdata(d3_rd), .in_port(d3_in),
        .irq(d3_irq)
    );

    typedef struct {
        logic        cs;
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read0(input logic [1:0] a, input logic [31:0] exp, input string name);
        d0_addr = a;
        tick();
        check(name, d0_rd, exp);
    endtask

    task automatic write0(input logic [1:0] a, input logic [31:0] d);
        d0_cs = 1'b1; d0_wn = 1'b0; d0_addr = a; d0_wd = d;
        tick();
        d0_cs = 1'b0; d0_wn = 1'b1; d0_addr = 2'd0;
    endtask

    // One bus op, then an idle cycle so irq reflects the op's effect.
    task automatic apply_vec(input vec_t v, input int idx);
        d0_cs = v.cs; d0_wn = ~v.wr; d0_addr = v.addr; d0_wd = v.wdata;
        tick();
        d0_cs = 1'b0; d0_wn = 1'b1;
        if (!v.wr) check($sformatf("vec%0d_rd", idx), d0_rd, v.exp_rd);
        tick();
        check($sformatf("vec%0d_irq", idx), {31'd0, d0_irq}, {31'd0, v.exp_irq});
    endtask

    vec_t vecs[14];

    initial begin
        // State on entry: data 0x85, irqmask 0x04, edgecapture 0x04, irq 1.
        vecs[0]  = '{1'b0, 1'b0, 2'd0, 32'h0,        32'h85, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 2'd1, 32'h0,        32'h04, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 2'd3, 32'h0,        32'h04, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 2'd2, 32'h0,        32'h00, 1'b1};
        vecs[4]  = '{1'b1, 1'b1, 2'd3, 32'h04,       32'h00, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 2'd3, 32'h0,        32'h00, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 2'd0, 32'hFF,       32'h00, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 2'd0, 32'h0,        32'h85, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 2'd2, 32'hFF,       32'h00, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 2'd2, 32'h0,        32'h00, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 2'd1, 32'hFFFFFFFF, 32'h00, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 2'd1, 32'h0,        32'hFF, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 2'd1, 32'h04,       32'h00, 1'b0}; // no chipselect
        vecs[13] = '{1'b0, 1'b0, 2'd1, 32'h0,        32'hFF, 1'b0};

        reset_n = 1'b0;
        d0_cs = 0; d0_wn = 1; d0_addr = 0; d0_wd = 0; d0_in = 8'h81;
        d2_cs = 0; d2_wn = 1; d2_addr = 0; d2_wd = 0; d2_in = 8'h01;
        d3_cs = 0; d3_wn = 1; d3_addr = 0; d3_wd = 0; d3_in = 3'b111;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rd", d0_rd, 32'h0);
        check("reset_irq", {31'd0, d0_irq}, 32'h0);
        reset_n = 1'b1;

        // 1: switches on at reset are primed without edges
        repeat (6) tick();
        check("t1_data", d0_rd, 32'h81);
        check("t1_irq", {31'd0, d0_irq}, 32'h0);
        read0(2'd3, 32'h0, "t1_edgecap");

        // 2: bit 2 rising, accepted on the 6th edge after the change
        write0(2'd1, 32'h04);
        tick();
        d0_in = 8'h85;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 6) begin
                check("t2_rd_k6", d0_rd, 32'h81);
                check("t2_irq_k6", {31'd0, d0_irq}, 32'h0);
            end
            if (k == 7) begin
                check("t2_rd_k7", d0_rd, 32'h85);
                check("t2_irq_k7", {31'd0, d0_irq}, 32'h1);
            end
        end

        // 3: register map table
        for (int i = 0; i < 14; i++) apply_vec(vecs[i], i);
        write0(2'd1, 32'h04);

        // 4: glitch rejection then acceptance on bit 5
        tick();
        d0_in = 8'hA5;
        repeat (3) tick();
        d0_in = 8'h85;
        repeat (10) tick();
        read0(2'd0, 32'h85, "t4_glitch_data");
        read0(2'd3, 32'h0, "t4_glitch_edgecap");
        check("t4_glitch_irq", {31'd0, d0_irq}, 32'h0);
        d0_in = 8'hA5;
        repeat (4) tick();
        d0_in = 8'h85;
        repeat (12) tick();
        read0(2'd3, 32'h20, "t4_pulse_edgecap");
        read0(2'd0, 32'h85, "t4_pulse_data_back");
        check("t4_pulse_irq", {31'd0, d0_irq}, 32'h0);
        write0(2'd3, 32'h20);
        read0(2'd3, 32'h0, "t4_w1c");

        // Reset mid-debounce: priming reloads without edges
        d0_addr = 2'd0;
        d0_in = 8'h87;
        repeat (4) tick();
        reset_n = 1'b0;
        tick();
        check("mid_reset_rd", d0_rd, 32'h0);
        reset_n = 1'b1;
        repeat (6) tick();
        check("mid_reset_data", d0_rd, 32'h87);
        read0(2'd3, 32'h0, "mid_reset_edgecap");
        read0(2'd1, 32'h0, "mid_reset_mask");
        check("mid_reset_irq", {31'd0, d0_irq}, 32'h0);

        // 5: any-edge, W1C coincident with the capture set
        check("t5_primed", d2_rd, 32'h01);
        d2_in = 8'h00;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 5) begin
                d2_cs = 1; d2_wn = 0; d2_addr = 2'd3; d2_wd = 32'h01;
            end
            if (k == 6) begin
                d2_cs = 0; d2_wn = 1;
                check("t5_rd_before", d2_rd, 32'h0);
            end
            if (k == 7) check("t5_set_wins", d2_rd, 32'h01);
        end
        d2_cs = 1; d2_wn = 0; d2_wd = 32'h01;
        tick();
        d2_cs = 0; d2_wn = 1;
        tick();
        check("t5_cleared", d2_rd, 32'h0);
        d2_in = 8'h01;
        repeat (8) tick();
        check("t5_rise_any", d2_rd, 32'h01);
        check("t5_irq_masked", {31'd0, d2_irq}, 32'h0);
        d2_cs = 1; d2_wn = 0; d2_addr = 2'd1; d2_wd = 32'h01;
        tick();
        d2_cs = 0; d2_wn = 1; d2_addr = 2'd3;
        tick();
        check("t5_irq", {31'd0, d2_irq}, 32'h1);

        // 6: WIDTH=3 build and read latency
        check("t6_data", d3_rd, 32'h7);
        d3_addr = 2'd2;
        #1;
        check("t6_no_comb_path", d3_rd, 32'h7);
        tick();
        check("t6_reserved", d3_rd, 32'h0);
        d3_addr = 2'd0;
        tick();
        check("t6_data_again", d3_rd, 32'h7);
        d3_cs = 1; d3_wn = 0; d3_addr = 2'd1; d3_wd = 32'hFFFFFFFF;
        tick();
        d3_cs = 0; d3_wn = 1;
        tick();
        check("t6_mask_width", d3_rd, 32'h7);
        check("t6_irq", {31'd0, d3_irq}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
